// File: rtl/ternary_pkg.sv
// Shared definitions for the ternary systolic-array tile controller.
package ternary_pkg;

    localparam int TM_SLICES  = 2;
    localparam int TM_OUTPUTS = 16;

    // 2-bit ternary weight encoding; any code with bit 1 set is -1
    localparam logic [1:0] WT_ZERO = 2'b00;
    localparam logic [1:0] WT_POS  = 2'b01;
    localparam logic [1:0] WT_NEG  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_WAIT_OUT,
        S_READOUT
    } state_t;

endpackage

// File: rtl/readout_framer.sv
// Frames the OUTPUTS-beat accumulator readout that follows a copy strobe:
// valid for exactly OUTPUTS cycles, index tracks the array's queue counter.
module readout_framer
    import ternary_pkg::*;
#(
    parameter int OUTPUTS = TM_OUTPUTS
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_strobe,
    output logic                       o_active,
    output logic [$clog2(OUTPUTS)-1:0] o_index,
    output logic                       o_done
);

    localparam int IW = $clog2(OUTPUTS);

    logic          r_active;
    logic [IW-1:0] r_index;
    logic          w_last;

    assign w_last   = (r_index == IW'(OUTPUTS - 1));
    assign o_active = r_active;
    assign o_index  = r_index;
    assign o_done   = r_active && w_last;

    // Readout beat counter: armed by the strobe, free-running until the last beat
    always_ff @(posedge clk) begin
        if (reset) begin
            r_active <= 1'b0;
            r_index  <= '0;
        end else if (i_strobe) begin
            r_active <= 1'b1;
            r_index  <= '0;
        end else if (r_active) begin
            if (w_last) begin
                r_active <= 1'b0;
                r_index  <= '0;
            end else begin
                r_index <= r_index + IW'(1);
            end
        end
    end

endmodule

// File: rtl/ternary_matmul_sequencer.sv
// Tile-level controller for the ternary systolic array: loads K vectors of
// SLICES beats aligned to the array's slice counter, inserts zero bubbles on
// host stalls, drains the pipeline, fires copy/clear/restart on the exact
// cycle, and frames the accumulator readout.
module ternary_matmul_sequencer
    import ternary_pkg::*;
#(
    parameter int SLICES  = TM_SLICES,
    parameter int OUTPUTS = TM_OUTPUTS,
    parameter int K_BITS  = 12,
    parameter int DRAIN   = SLICES
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [K_BITS-1:0]          k_len,
    output logic                       busy,
    output logic                       done,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [7:0]                 in_weights,
    input  logic [7:0]                 in_top,
    output logic [7:0]                 arr_weights,
    output logic [7:0]                 arr_top,
    output logic                       arr_reset_accumulators,
    output logic                       arr_copy_to_out_queue,
    output logic                       arr_restart_out_queue,
    output logic                       out_valid,
    output logic [$clog2(OUTPUTS)-1:0] out_index,
    output logic                       proto_err
);

    localparam int PW = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

    state_t                     r_state;
    logic [PW-1:0]              r_phase;
    logic                       r_open;
    logic [K_BITS-1:0]          r_k_len;
    logic [K_BITS-1:0]          r_vec_cnt;
    logic [DW-1:0]              r_drain_cnt;
    logic                       r_proto_err;

    logic                       w_ready;
    logic                       w_accept;
    logic                       w_beat;
    logic                       w_last_beat;
    logic                       w_last_vec;
    logic                       w_drain_end;
    logic                       w_strobe;
    logic                       w_ro_active;
    logic                       w_ro_done;
    logic [$clog2(OUTPUTS)-1:0] w_ro_index;

    // A vector may only open on phase 0; once open it owns the remaining beats
    assign w_ready     = (r_state == S_LOAD) && ((r_phase == '0) || r_open);
    assign w_accept    = w_ready && in_valid && !reset;
    // Beats of an open vector count even when the host drops them
    assign w_beat      = w_ready && (r_open || in_valid);
    assign w_last_beat = w_beat && (r_phase == PW'(SLICES - 1));
    assign w_last_vec  = (r_vec_cnt == r_k_len - K_BITS'(1));
    assign w_drain_end = (r_state == S_DRAIN) && (r_drain_cnt == DW'(DRAIN - 1));
    // Strobe waits for any previous readout to finish before restarting the queue
    assign w_strobe    = (w_drain_end || (r_state == S_WAIT_OUT)) && !w_ro_active;

    assign in_ready               = w_ready && !reset;
    assign arr_weights            = w_accept ? in_weights : {4{WT_ZERO}};
    assign arr_top                = w_accept ? in_top : '0;
    assign arr_reset_accumulators = reset || w_strobe;
    assign arr_copy_to_out_queue  = w_strobe && !reset;
    assign arr_restart_out_queue  = w_strobe && !reset;
    assign busy                   = (r_state != S_IDLE) && !reset;
    assign done                   = w_ro_done && !reset;
    assign out_valid              = w_ro_active && !reset;
    assign out_index              = reset ? '0 : w_ro_index;
    assign proto_err              = r_proto_err && !reset;

    readout_framer #(
        .OUTPUTS (OUTPUTS)
    ) u_framer (
        .clk      (clk),
        .reset    (reset),
        .i_strobe (w_strobe),
        .o_active (w_ro_active),
        .o_index  (w_ro_index),
        .o_done   (w_ro_done)
    );

    // Tile FSM plus the free-running phase that mirrors the array slice counter.
    // READOUT accepts a new start so the next tile can load under the readout.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_phase     <= '0;
            r_open      <= 1'b0;
            r_k_len     <= '0;
            r_vec_cnt   <= '0;
            r_drain_cnt <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_phase <= (r_phase == PW'(SLICES - 1)) ? '0 : r_phase + PW'(1);
            case (r_state)
                S_IDLE, S_READOUT: begin
                    if (start) begin
                        r_k_len     <= k_len;
                        r_vec_cnt   <= '0;
                        r_open      <= 1'b0;
                        r_drain_cnt <= '0;
                        r_state     <= (k_len == '0) ? S_DRAIN : S_LOAD;
                    end else if (r_state == S_READOUT && w_ro_done) begin
                        r_state <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    if (w_beat) begin
                        if (r_open && !in_valid) begin
                            r_proto_err <= 1'b1;
                        end
                        r_open <= !w_last_beat;
                        if (w_last_beat) begin
                            r_vec_cnt <= r_vec_cnt + K_BITS'(1);
                            if (w_last_vec) begin
                                r_drain_cnt <= '0;
                                r_state     <= S_DRAIN;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_drain_end) begin
                        r_state <= w_ro_active ? S_WAIT_OUT : S_READOUT;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + DW'(1);
                    end
                end
                S_WAIT_OUT: begin
                    if (!w_ro_active) begin
                        r_state <= S_READOUT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ternary_matmul_sequencer.sv
// Randomized self-checking bench for ternary_matmul_sequencer. A behavioural
// array model accumulates what the sequencer drives; expected sums, strobe
// cycles and readout framing come from the tile-level rules.
module tb_ternary_matmul_sequencer;
    import ternary_pkg::*;

    localparam int SLICES  = TM_SLICES;
    localparam int OUTPUTS = TM_OUTPUTS;
    localparam int DRAIN   = 2;
    localparam longint SENTINEL = 64'sh7eadbeef12345678;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [11:0] k_len = '0;
    logic        busy, done, in_ready;
    logic        in_valid = 1'b0;
    logic [7:0]  in_weights = '0;
    logic [7:0]  in_top = '0;
    logic [7:0]  arr_weights, arr_top;
    logic        arr_reset_accumulators, arr_copy_to_out_queue, arr_restart_out_queue;
    logic        out_valid;
    logic [3:0]  out_index;
    logic        proto_err;

    int     n_checks = 0;
    int     n_errors = 0;
    int     cyc = 0;
    int     slice = 0;
    longint acc = 0;
    longint snap = 0;
    int     copy_cyc = -1;
    int     ro_s = -1000;
    int     ro_end = -1000;
    bit     exp_err = 1'b0;
    int     strobe_q[$];

    ternary_matmul_sequencer #(
        .SLICES  (SLICES),
        .OUTPUTS (OUTPUTS),
        .K_BITS  (12),
        .DRAIN   (DRAIN)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .start                  (start),
        .k_len                  (k_len),
        .busy                   (busy),
        .done                   (done),
        .in_valid               (in_valid),
        .in_ready               (in_ready),
        .in_weights             (in_weights),
        .in_top                 (in_top),
        .arr_weights            (arr_weights),
        .arr_top                (arr_top),
        .arr_reset_accumulators (arr_reset_accumulators),
        .arr_copy_to_out_queue  (arr_copy_to_out_queue),
        .arr_restart_out_queue  (arr_restart_out_queue),
        .out_valid              (out_valid),
        .out_index              (out_index),
        .proto_err              (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Lane-weighted dot product of one beat, so lane or sign errors change the sum
    function automatic longint beat_val(input logic [7:0] w, input logic [7:0] top);
        longint s;
        longint t;
        logic [1:0] wl;
        s = 0;
        t = longint'($signed(top));
        for (int l = 0; l < 4; l++) begin
            wl = w[2*l +: 2];
            if (wl == WT_POS) s += t * (l + 1);
            else if ((wl & WT_NEG) != WT_ZERO) s -= t * (l + 1);
        end
        return s;
    endfunction

    // Cycle counter and the array's own slice counter
    always @(posedge clk) begin
        cyc <= cyc + 1;
        slice <= reset ? 0 : (slice + 1) % SLICES;
    end

    // Array model plus per-cycle strobe and readout framing checks
    always @(negedge clk) begin
        bit exp_str;
        bit exp_ov;
        if (reset) begin
            chk("rst_busy", longint'(busy), 0);
            chk("rst_in_ready", longint'(in_ready), 0);
            chk("rst_out_valid", longint'(out_valid), 0);
            chk("rst_done", longint'(done), 0);
            chk("rst_proto_err", longint'(proto_err), 0);
            chk("rst_copy", longint'(arr_copy_to_out_queue), 0);
            chk("rst_clear", longint'(arr_reset_accumulators), 1);
            chk("rst_weights", longint'(arr_weights), 0);
            acc = 0;
            ro_s = -1000;
            strobe_q.delete();
        end else begin
            exp_str = (strobe_q.size() > 0) && (strobe_q[0] == cyc);
            if (exp_str) begin
                ro_s = cyc;
                void'(strobe_q.pop_front());
            end
            chk("copy", longint'(arr_copy_to_out_queue), longint'(exp_str));
            chk("clear", longint'(arr_reset_accumulators), longint'(exp_str));
            chk("restart", longint'(arr_restart_out_queue), longint'(exp_str));
            exp_ov = (cyc >= ro_s + 1) && (cyc <= ro_s + OUTPUTS);
            chk("out_valid", longint'(out_valid), longint'(exp_ov));
            if (exp_ov) chk("out_index", longint'(out_index), cyc - ro_s - 1);
            chk("done", longint'(done), longint'(cyc == ro_s + OUTPUTS));
            if (arr_copy_to_out_queue) begin
                snap = acc;
                copy_cyc = cyc;
            end
            if (arr_reset_accumulators) acc = 0;
            else acc += beat_val(arr_weights, arr_top) * (slice + 1);
        end
    end

    task automatic run_tile(input int k, input int n_force, input int stall_pct,
                            input bit inject_err, input bit directed, input int abort_at);
        int b, v, g, stalls, readies, t0, fin, f, es, nf;
        bit err_done, finished;
        longint sum;
        b = 0; v = 0; g = 0; stalls = 0; readies = 0; fin = 0; es = -1;
        nf = n_force; err_done = 1'b0; finished = 1'b0; sum = 0;
        @(posedge clk); #1;
        snap = SENTINEL;
        copy_cyc = -1;
        start = 1'b1;
        k_len = 12'(k);
        t0 = cyc;
        in_valid = 1'b0;
        in_weights = 8'($urandom);
        in_top = 8'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        k_len = 12'($urandom);
        for (int n = 0; n < 200; n++) begin
            if (n == abort_at) begin
                reset = 1'b1;
                in_valid = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                reset = 1'b0;
                exp_err = 1'b0;
                ro_end = -1000;
                chk("busy_after_reset", longint'(busy), 0);
                chk("ready_after_reset", longint'(in_ready), 0);
                chk("out_valid_after_reset", longint'(out_valid), 0);
                return;
            end
            in_valid = 1'b0;
            in_weights = 8'($urandom);
            in_top = 8'($urandom);
            if (in_ready) begin
                readies++;
                if (b == 0) begin
                    if (nf > 0 || $urandom_range(99) < stall_pct) begin
                        nf--;
                        stalls++;
                    end else begin
                        in_valid = 1'b1;
                        if (directed) begin in_weights = 8'h55; in_top = 8'(g + 1); end
                        g++;
                        sum += beat_val(in_weights, in_top);
                        b = 1;
                    end
                end else if (inject_err && !err_done) begin
                    err_done = 1'b1;
                    exp_err = 1'b1;
                    g++;
                    b++;
                end else begin
                    in_valid = 1'b1;
                    if (directed) begin in_weights = 8'h55; in_top = 8'(g + 1); end
                    g++;
                    sum += beat_val(in_weights, in_top) * (b + 1);
                    b++;
                end
                if (b == SLICES) begin
                    b = 0;
                    v++;
                    if (v == k) fin = cyc;
                end
            end
            if (es < 0 && v == k) begin
                f = ((k == 0) ? t0 : fin) + DRAIN;
                es = (f <= ro_end) ? ro_end + 1 : f;
                strobe_q.push_back(es);
                ro_end = es + OUTPUTS;
            end
            if (es >= 0 && cyc > es) begin
                finished = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("tile_in_time", longint'(finished), 1);
        chk("vectors", v, k);
        chk("ready_cycles", readies, k * SLICES + stalls);
        chk("strobe_cycle", copy_cyc, es);
        chk("acc_copy", snap, sum);
        chk("proto_err", longint'(proto_err), longint'(exp_err));
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 64; n++) begin
            if (!busy) break;
            @(posedge clk); #1;
        end
        chk("idle_in_time", longint'(busy), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("init_busy", longint'(busy), 0);
        chk("init_proto_err", longint'(proto_err), 0);

        // Directed tile, then the same data with two stalled vector slots
        run_tile(3, 0, 0, 1'b0, 1'b1, -1);
        wait_idle();
        run_tile(3, 2, 0, 1'b0, 1'b1, -1);
        wait_idle();

        // Dropped mid-vector beat: error is raised and stays raised
        run_tile(4, 0, 20, 1'b1, 1'b0, -1);
        wait_idle();
        run_tile(2, 0, 30, 1'b0, 1'b0, -1);
        wait_idle();

        // Empty tile
        run_tile(0, 0, 0, 1'b0, 1'b0, -1);
        wait_idle();

        // Second tile started under the first readout
        run_tile(2, 0, 0, 1'b0, 1'b0, -1);
        run_tile(1, 0, 0, 1'b0, 1'b0, -1);
        wait_idle();

        // Reset mid-load while a readout is in flight, then a fresh tile
        run_tile(1, 0, 0, 1'b0, 1'b0, -1);
        run_tile(5, 0, 0, 1'b0, 1'b0, 4);
        run_tile(3, 0, 30, 1'b0, 1'b0, -1);
        wait_idle();

        for (int t = 0; t < 8; t++) begin
            run_tile(int'($urandom_range(6)), 0, 30, ($urandom_range(3) == 0), 1'b0, -1);
            if ($urandom_range(1) == 0) wait_idle();
        end
        wait_idle();
        repeat (20) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
